alarm_controller: RTL and testbench

ALARM_CONTROLLER -- requirements
Module: Alarm_Controller

---
 rtl/alarm_controller.sv | 160 ++++++++++++++++
 tb/tb_alarm_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm clock controller: stores a 24 h BCD alarm time, rings on a minute match,
// and handles snooze, stop/disarm and a ringing timeout counted in input ticks.
module alarm_controller #(
   parameter int TICKS_PER_SEC  = 10,
   parameter int RING_SECONDS   = 60,
   parameter int SNOOZE_SECONDS = 300
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       Set_Alarm,
   input  logic       Alarm_Off,
   input  logic       Snooze,
   input  logic       MIN,
   input  logic       HR,
   input  logic [1:0] time_h_t,
   input  logic [3:0] time_h_u,
   input  logic [2:0] time_m_t,
   input  logic [3:0] time_m_u,
   input  logic [2:0] time_s_t,
   input  logic [3:0] time_s_u,
   output logic [1:0] alarm_h_t,
   output logic [3:0] alarm_h_u,
   output logic [2:0] alarm_m_t,
   output logic [3:0] alarm_m_u,
   output logic       Alarm_Out,
   output logic       armed,
   output logic [2:0] state
);

   localparam int MAX_SECONDS = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
   localparam int TW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int SW = (MAX_SECONDS > 2) ? $clog2(MAX_SECONDS) : 1;
   localparam logic [TW-1:0] TICK_LAST   = TW'(TICKS_PER_SEC - 1);
   localparam logic [TW-1:0] TICK_HALF   = TW'(TICKS_PER_SEC / 2);
   localparam logic [SW-1:0] RING_LAST   = SW'(RING_SECONDS - 1);
   localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SECONDS - 1);

   typedef enum logic [2:0] {
      DISARMED = 3'd0,
      ARMED    = 3'd1,
      SET      = 3'd2,
      RINGING  = 3'd3,
      SNOOZING = 3'd4
   } state_t;

   state_t        state_q;
   logic [TW-1:0] tick_cnt;
   logic [SW-1:0] sec_cnt;
   logic          match_q;
   logic          off_prev;
   logic          snooze_prev;

   logic match;
   logic off_edge;
   logic snooze_edge;
   logic tick_wrap;

   assign match = (time_h_t == alarm_h_t) && (time_h_u == alarm_h_u) &&
                  (time_m_t == alarm_m_t) && (time_m_u == alarm_m_u) &&
                  (time_s_t == 3'd0) && (time_s_u == 4'd0);
   assign off_edge    = Alarm_Off & ~off_prev;
   assign snooze_edge = Snooze & ~snooze_prev;
   assign tick_wrap   = tick && (tick_cnt == TICK_LAST);

   assign state     = state_q;
   assign armed     = (state_q == ARMED) || (state_q == RINGING) || (state_q == SNOOZING);
   assign Alarm_Out = (state_q == RINGING) && (tick_cnt < TICK_HALF);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= DISARMED;
         alarm_h_t   <= 2'd0;
         alarm_h_u   <= 4'd7;
         alarm_m_t   <= 3'd0;
         alarm_m_u   <= 4'd0;
         tick_cnt    <= '0;
         sec_cnt     <= '0;
         match_q     <= 1'b0;
         off_prev    <= 1'b0;
         snooze_prev <= 1'b0;
      end else begin
         match_q     <= match;
         off_prev    <= Alarm_Off;
         snooze_prev <= Snooze;

         // Set mode wins over everything; digit editing only happens once already in SET.
         if (Set_Alarm) begin
            state_q <= SET;
            if (state_q == SET && tick && MIN) begin
               if (alarm_m_u == 4'd9) begin
                  alarm_m_u <= 4'd0;
                  alarm_m_t <= (alarm_m_t == 3'd5) ? 3'd0 : alarm_m_t + 3'd1;
               end else begin
                  alarm_m_u <= alarm_m_u + 4'd1;
               end
            end
            if (state_q == SET && tick && HR) begin
               if (alarm_h_t == 2'd2 && alarm_h_u == 4'd3) begin
                  alarm_h_t <= 2'd0;
                  alarm_h_u <= 4'd0;
               end else if (alarm_h_u == 4'd9) begin
                  alarm_h_u <= 4'd0;
                  alarm_h_t <= alarm_h_t + 2'd1;
               end else begin
                  alarm_h_u <= alarm_h_u + 4'd1;
               end
            end
         end else begin
            case (state_q)
               SET: state_q <= ARMED;
               ARMED: begin
                  // Only a fresh match fires, so a time already matching on arm stays quiet.
                  if (off_edge) begin
                     state_q <= DISARMED;
                  end else if (match && !match_q) begin
                     state_q  <= RINGING;
                     tick_cnt <= '0;
                     sec_cnt  <= '0;
                  end
               end
               RINGING: begin
                  if (off_edge) begin
                     state_q <= ARMED;
                  end else if (snooze_edge) begin
                     state_q  <= SNOOZING;
                     tick_cnt <= '0;
                     sec_cnt  <= '0;
                  end else if (tick_wrap && sec_cnt == RING_LAST) begin
                     state_q  <= ARMED;
                     tick_cnt <= '0;
                     sec_cnt  <= '0;
                  end else if (tick_wrap) begin
                     tick_cnt <= '0;
                     sec_cnt  <= sec_cnt + 1'b1;
                  end else if (tick) begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               SNOOZING: begin
                  if (off_edge) begin
                     state_q <= ARMED;
                  end else if (tick_wrap && sec_cnt == SNOOZE_LAST) begin
                     state_q  <= RINGING;
                     tick_cnt <= '0;
                     sec_cnt  <= '0;
                  end else if (tick_wrap) begin
                     tick_cnt <= '0;
                     sec_cnt  <= sec_cnt + 1'b1;
                  end else if (tick) begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               default: state_q <= state_q;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed self-checking bench for alarm_controller: set mode, wrap, trigger,
// timeout, snooze and reset behaviour with hand-computed expectations.
module tb_alarm_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       Set_Alarm;
   logic       Alarm_Off;
   logic       Snooze;
   logic       MIN;
   logic       HR;
   logic [1:0] time_h_t;
   logic [3:0] time_h_u;
   logic [2:0] time_m_t;
   logic [3:0] time_m_u;
   logic [2:0] time_s_t;
   logic [3:0] time_s_u;
   logic [1:0] alarm_h_t;
   logic [3:0] alarm_h_u;
   logic [2:0] alarm_m_t;
   logic [3:0] alarm_m_u;
   logic       Alarm_Out;
   logic       armed;
   logic [2:0] state;

   int errors = 0;
   int checks = 0;

   alarm_controller dut (
      .clk(clk), .reset(reset), .tick(tick), .Set_Alarm(Set_Alarm),
      .Alarm_Off(Alarm_Off), .Snooze(Snooze), .MIN(MIN), .HR(HR),
      .time_h_t(time_h_t), .time_h_u(time_h_u), .time_m_t(time_m_t), .time_m_u(time_m_u),
      .time_s_t(time_s_t), .time_s_u(time_s_u),
      .alarm_h_t(alarm_h_t), .alarm_h_u(alarm_h_u), .alarm_m_t(alarm_m_t), .alarm_m_u(alarm_m_u),
      .Alarm_Out(Alarm_Out), .armed(armed), .state(state)
   );

   always #5 clk = ~clk;

   // Alarm time packed as hex HHMM so 07:00 reads as 16'h0700.
   function automatic logic [15:0] alarmHex();
      return {2'b00, alarm_h_t, alarm_h_u, 1'b0, alarm_m_t, alarm_m_u};
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One tick per two clock cycles; inputs change only at falling edges.
   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic setTime(input int h, input int m, input int s);
      time_h_t = 2'(h / 10);
      time_h_u = 4'(h % 10);
      time_m_t = 3'(m / 10);
      time_m_u = 4'(m % 10);
      time_s_t = 3'(s / 10);
      time_s_u = 4'(s % 10);
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; Set_Alarm = 1'b0; Alarm_Off = 1'b0;
      Snooze = 1'b0; MIN = 1'b0; HR = 1'b0;
      setTime(12, 34, 56);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset_state", 16'(state), 16'd0);
      checkOutput("reset_alarm", alarmHex(), 16'h0700);
      checkOutput("reset_buzzer", 16'(Alarm_Out), 16'd0);
      checkOutput("reset_armed", 16'(armed), 16'd0);

      $display("[TB] set mode: 18 hour ticks, 65 minute ticks");
      Set_Alarm = 1'b1;
      @(negedge clk);
      checkOutput("set_entry", 16'(state), 16'd2);
      HR = 1'b1; applyStimulus(18); HR = 1'b0;
      checkOutput("set_hours", alarmHex(), 16'h0100);
      MIN = 1'b1; applyStimulus(65); MIN = 1'b0;
      checkOutput("set_minutes", alarmHex(), 16'h0105);
      Set_Alarm = 1'b0;
      @(negedge clk);
      checkOutput("set_exit_state", 16'(state), 16'd1);
      checkOutput("set_exit_armed", 16'(armed), 16'd1);

      $display("[TB] wrap 23:59 -> 00:00");
      Set_Alarm = 1'b1;
      @(negedge clk);
      HR = 1'b1; applyStimulus(22); HR = 1'b0;
      MIN = 1'b1; applyStimulus(54);
      checkOutput("pre_wrap", alarmHex(), 16'h2359);
      HR = 1'b1; applyStimulus(1); HR = 1'b0; MIN = 1'b0;
      checkOutput("wrap_both", alarmHex(), 16'h0000);
      HR = 1'b1; applyStimulus(7); HR = 1'b0;
      checkOutput("set_0700", alarmHex(), 16'h0700);

      $display("[TB] match already true on arming must not fire");
      setTime(7, 0, 0);
      Set_Alarm = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("no_fire_on_arm", 16'(state), 16'd1);

      $display("[TB] trigger at 07:00:00");
      setTime(6, 59, 59);
      @(negedge clk);
      checkOutput("armed_before", 16'(state), 16'd1);
      setTime(7, 0, 0);
      @(negedge clk);
      checkOutput("ring_state", 16'(state), 16'd3);
      checkOutput("ring_buzz_t0", 16'(Alarm_Out), 16'd1);
      applyStimulus(4);
      checkOutput("ring_buzz_t4", 16'(Alarm_Out), 16'd1);
      applyStimulus(1);
      checkOutput("ring_buzz_t5", 16'(Alarm_Out), 16'd0);
      applyStimulus(4);
      checkOutput("ring_buzz_t9", 16'(Alarm_Out), 16'd0);
      applyStimulus(1);
      checkOutput("ring_buzz_t10", 16'(Alarm_Out), 16'd1);
      checkOutput("no_retrigger", 16'(state), 16'd3);

      $display("[TB] ring timeout after 600 ticks");
      applyStimulus(589);
      checkOutput("timeout_599", 16'(state), 16'd3);
      applyStimulus(1);
      checkOutput("timeout_600", 16'(state), 16'd1);
      checkOutput("timeout_buzz", 16'(Alarm_Out), 16'd0);

      $display("[TB] snooze cycle");
      setTime(6, 59, 59);
      @(negedge clk);
      setTime(7, 0, 0);
      @(negedge clk);
      checkOutput("ring_again", 16'(state), 16'd3);
      Snooze = 1'b1;
      @(negedge clk);
      Snooze = 1'b0;
      checkOutput("snooze_state", 16'(state), 16'd4);
      checkOutput("snooze_buzz", 16'(Alarm_Out), 16'd0);
      checkOutput("snooze_armed", 16'(armed), 16'd1);
      applyStimulus(1000);
      Snooze = 1'b1;
      @(negedge clk);
      Snooze = 1'b0;
      checkOutput("snooze_ignored", 16'(state), 16'd4);
      applyStimulus(1999);
      checkOutput("snooze_2999", 16'(state), 16'd4);
      applyStimulus(1);
      checkOutput("snooze_rering", 16'(state), 16'd3);
      checkOutput("rering_buzz", 16'(Alarm_Out), 16'd1);
      Alarm_Off = 1'b1;
      @(negedge clk);
      checkOutput("off_to_armed", 16'(state), 16'd1);
      @(negedge clk);
      checkOutput("off_held_no_edge", 16'(state), 16'd1);
      Alarm_Off = 1'b0;
      @(negedge clk);
      Alarm_Off = 1'b1;
      @(negedge clk);
      Alarm_Off = 1'b0;
      checkOutput("off_disarm", 16'(state), 16'd0);
      checkOutput("disarm_armed", 16'(armed), 16'd0);

      $display("[TB] disarmed ignores a fresh match");
      setTime(6, 59, 59);
      @(negedge clk);
      setTime(7, 0, 0);
      @(negedge clk);
      checkOutput("disarmed_match", 16'(state), 16'd0);

      $display("[TB] reset mid-ring restores 07:00");
      Set_Alarm = 1'b1;
      @(negedge clk);
      HR = 1'b1; applyStimulus(1); HR = 1'b0;
      Set_Alarm = 1'b0;
      @(negedge clk);
      checkOutput("alarm_0800", alarmHex(), 16'h0800);
      setTime(7, 59, 59);
      @(negedge clk);
      setTime(8, 0, 0);
      @(negedge clk);
      checkOutput("ring_0800", 16'(state), 16'd3);
      applyStimulus(3);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("midring_reset_state", 16'(state), 16'd0);
      checkOutput("midring_reset_alarm", alarmHex(), 16'h0700);
      checkOutput("midring_reset_buzz", 16'(Alarm_Out), 16'd0);

      $display("[TB] Set_Alarm while ringing");
      Set_Alarm = 1'b1;
      @(negedge clk);
      Set_Alarm = 1'b0;
      @(negedge clk);
      setTime(6, 59, 59);
      @(negedge clk);
      setTime(7, 0, 0);
      @(negedge clk);
      checkOutput("ring_before_set", 16'(Alarm_Out), 16'd1);
      Set_Alarm = 1'b1;
      @(negedge clk);
      checkOutput("ring_to_set", 16'(state), 16'd2);
      checkOutput("set_buzz_off", 16'(Alarm_Out), 16'd0);

      $display("[TB] reset overrides set mode");
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midset_reset", 16'(state), 16'd0);
      reset = 1'b0;
      Set_Alarm = 1'b0;
      @(negedge clk);
      checkOutput("after_reset_stays", 16'(state), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
